// File: rtl/jtcps1_sndlatch_if.sv
`default_nettype none
// ============================================================================
// Module   : jtcps1_sndlatch_if
// Brief    : Main-CPU write bus and sound-side latch signals of the CPS1
//            sound command latch block.
// Revision : 1.0 - initial release
// ============================================================================
interface jtcps1_sndlatch_if;
    logic       main_cs;
    logic       main_rnw;
    logic [1:0] main_dsn;
    logic [2:0] main_addr;
    logic [7:0] main_din;
    logic       snd_rd0;
    logic [7:0] snd_latch0;
    logic [7:0] snd_latch1;
    logic       pending;
    logic       full;
    logic       ovf;

    modport master (
        output main_cs, main_rnw, main_dsn, main_addr, main_din, snd_rd0,
        input  snd_latch0, snd_latch1, pending, full, ovf
    );

    modport slave (
        input  main_cs, main_rnw, main_dsn, main_addr, main_din, snd_rd0,
        output snd_latch0, snd_latch1, pending, full, ovf
    );
endinterface
`default_nettype wire

// File: rtl/jtcps1_sndlatch.sv
`default_nettype none
// ============================================================================
// Module   : jtcps1_sndlatch
// Brief    : 68000-side writer for the CPS1 sound latches; latch 0 is queued
//            in a small FIFO, latch 1 is a plain register.
// Revision : 1.0 - initial release
// ============================================================================
module jtcps1_sndlatch #(
    parameter int AW = 3
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    jtcps1_sndlatch_if.slave  bus
);

    localparam int            c_depth    = 1 << AW;
    localparam logic [AW:0]   c_cnt_zero = '0;
    localparam logic [AW:0]   c_cnt_one  = (AW+1)'(1);
    localparam logic [AW:0]   c_cnt_full = (AW+1)'(c_depth);
    localparam logic [AW-1:0] c_ptr_one  = AW'(1);
    localparam logic [2:0]    c_addr_l0  = 3'b000;
    localparam logic [2:0]    c_addr_l1  = 3'b100;

    logic          r_wr_l;
    logic          r_rd_l;
    logic [AW:0]   r_count;
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [7:0]    r_mem [c_depth];
    logic [7:0]    r_latch0;
    logic [7:0]    r_latch1;
    logic          r_pending;
    logic          r_full;
    logic          r_ovf;

    logic          w_wr;
    logic          w_wr_edge;
    logic          w_push_req;
    logic          w_l1_write;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic [AW:0]   w_count_nxt;
    logic [AW-1:0] w_rd_ptr_inc;
    logic [7:0]    w_latch0_nxt;
    logic          w_unused_dsn1;

    // Only the low byte lane carries latch data; the upper strobe is ignored.
    assign w_unused_dsn1 = bus.main_dsn[1];

    always_comb begin
        w_wr         = bus.main_cs & ~bus.main_rnw & ~bus.main_dsn[0];
        w_wr_edge    = w_wr & ~r_wr_l;
        w_push_req   = w_wr_edge & (bus.main_addr == c_addr_l0);
        w_l1_write   = w_wr_edge & (bus.main_addr == c_addr_l1);
        w_pop        = r_rd_l & ~bus.snd_rd0 & (r_count != c_cnt_zero);
        // A pop in the same cycle frees the slot the push needs when full.
        w_push       = w_push_req & ((r_count != c_cnt_full) | w_pop);
        w_drop       = w_push_req & (r_count == c_cnt_full) & ~w_pop;
        w_rd_ptr_inc = r_rd_ptr + c_ptr_one;
    end

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + c_cnt_one;
            2'b01:   w_count_nxt = r_count - c_cnt_one;
            default: w_count_nxt = r_count;
        endcase
    end

    // The head register keeps its last value when the queue drains,
    // mimicking a real latch that the Z80 may read again.
    always_comb begin
        w_latch0_nxt = r_latch0;
        if (w_push && ((r_count == c_cnt_zero) ||
                       (w_pop && (r_count == c_cnt_one)))) begin
            w_latch0_nxt = bus.main_din;
        end else if (w_pop && (r_count > c_cnt_one)) begin
            w_latch0_nxt = r_mem[w_rd_ptr_inc];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_l    <= 1'b0;
            r_rd_l    <= 1'b0;
            r_count   <= c_cnt_zero;
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_latch0  <= 8'hFF;
            r_latch1  <= 8'h00;
            r_pending <= 1'b0;
            r_full    <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_wr_l    <= w_wr;
            r_rd_l    <= bus.snd_rd0;
            r_count   <= w_count_nxt;
            r_latch0  <= w_latch0_nxt;
            r_pending <= (w_count_nxt != c_cnt_zero);
            r_full    <= (w_count_nxt == c_cnt_full);
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_ptr_inc;
            end
            if (w_l1_write) begin
                r_latch1 <= bus.main_din;
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Storage needs no reset: only slots covered by the count are ever read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.main_din;
        end
    end

    assign bus.snd_latch0 = r_latch0;
    assign bus.snd_latch1 = r_latch1;
    assign bus.pending    = r_pending;
    assign bus.full       = r_full;
    assign bus.ovf        = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_jtcps1_sndlatch.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtcps1_sndlatch
// Brief    : Directed self-checking bench for jtcps1_sndlatch.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jtcps1_sndlatch;

    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;

    jtcps1_sndlatch_if bus ();

    jtcps1_sndlatch #(.AW(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_idle();
        bus.main_cs   = 1'b0;
        bus.main_rnw  = 1'b1;
        bus.main_dsn  = 2'b11;
    endtask

    task automatic bus_drive(input logic [2:0] a, input logic [7:0] d, input logic [1:0] dsn);
        bus.main_cs   = 1'b1;
        bus.main_rnw  = 1'b0;
        bus.main_dsn  = dsn;
        bus.main_addr = a;
        bus.main_din  = d;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [7:0] d, input int hold);
        bus_drive(a, d, 2'b10);
        step(hold);
        bus_idle();
        step(1);
    endtask

    task automatic snd_read(input int hold);
        bus.snd_rd0 = 1'b1;
        step(hold);
        bus.snd_rd0 = 1'b0;
        step(1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus_idle();
        bus.main_addr = 3'b000;
        bus.main_din  = 8'h00;
        bus.snd_rd0   = 1'b0;

        // Reset values
        step(3);
        check("rst_latch0", bus.snd_latch0, 8'hFF);
        check("rst_latch1", bus.snd_latch1, 8'h00);
        check("rst_pending", {7'd0, bus.pending}, 8'h00);
        check("rst_full", {7'd0, bus.full}, 8'h00);
        check("rst_ovf", {7'd0, bus.ovf}, 8'h00);
        rst_n = 1'b1;
        step(3);
        check("idle_latch0", bus.snd_latch0, 8'hFF);
        check("idle_pending", {7'd0, bus.pending}, 8'h00);

        // Single command held for 6 clocks
        bus_drive(3'b000, 8'h23, 2'b10);
        step(1);
        check("single_latch0", bus.snd_latch0, 8'h23);
        check("single_pending", {7'd0, bus.pending}, 8'h01);
        step(5);
        bus_idle();
        step(1);
        bus.snd_rd0 = 1'b1;
        step(4);
        check("single_pending_during_rd", {7'd0, bus.pending}, 8'h01);
        bus.snd_rd0 = 1'b0;
        step(1);
        check("single_pending_after_rd", {7'd0, bus.pending}, 8'h00);
        check("single_latch0_kept", bus.snd_latch0, 8'h23);

        // Queue order
        bus_write(3'b000, 8'h01, 1);
        bus_write(3'b000, 8'h02, 1);
        bus_write(3'b000, 8'h03, 1);
        check("q_head", bus.snd_latch0, 8'h01);
        snd_read(1);
        check("q_second", bus.snd_latch0, 8'h02);
        snd_read(1);
        check("q_third", bus.snd_latch0, 8'h03);
        snd_read(1);
        check("q_pending_empty", {7'd0, bus.pending}, 8'h00);
        check("q_latch0_kept", bus.snd_latch0, 8'h03);

        // Overflow: nine writes into an 8-deep queue
        for (int i = 0; i < 9; i++) begin
            bus_write(3'b000, 8'h10 + 8'(i), 1);
            if (i == 6) check("ovf_not_full_at7", {7'd0, bus.full}, 8'h00);
            if (i == 7) begin
                check("ovf_full_at8", {7'd0, bus.full}, 8'h01);
                check("ovf_clear_at8", {7'd0, bus.ovf}, 8'h00);
            end
        end
        check("ovf_set", {7'd0, bus.ovf}, 8'h01);
        check("ovf_full_kept", {7'd0, bus.full}, 8'h01);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("ovf_pop%0d", i), bus.snd_latch0, 8'h10 + 8'(i));
            snd_read(1);
        end
        check("ovf_drained", {7'd0, bus.pending}, 8'h00);
        check("ovf_last_kept", bus.snd_latch0, 8'h17);
        check("ovf_sticky", {7'd0, bus.ovf}, 8'h01);

        // Simultaneous push + pop with one entry
        do_reset();
        bus_write(3'b000, 8'hAA, 1);
        bus.snd_rd0 = 1'b1;
        step(1);
        bus.snd_rd0 = 1'b0;
        bus_drive(3'b000, 8'hBB, 2'b10);
        step(1);
        check("sim1_latch0", bus.snd_latch0, 8'hBB);
        check("sim1_pending", {7'd0, bus.pending}, 8'h01);
        bus_idle();
        step(1);
        snd_read(1);
        check("sim1_single_entry", {7'd0, bus.pending}, 8'h00);

        // Simultaneous push + pop when full
        do_reset();
        for (int i = 0; i < 8; i++) bus_write(3'b000, 8'h20 + 8'(i), 1);
        check("simf_full", {7'd0, bus.full}, 8'h01);
        bus.snd_rd0 = 1'b1;
        step(1);
        bus.snd_rd0 = 1'b0;
        bus_drive(3'b000, 8'h28, 2'b10);
        step(1);
        bus_idle();
        step(1);
        check("simf_ovf", {7'd0, bus.ovf}, 8'h00);
        check("simf_full_kept", {7'd0, bus.full}, 8'h01);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("simf_pop%0d", i), bus.snd_latch0, 8'h21 + 8'(i));
            snd_read(1);
        end
        check("simf_drained", {7'd0, bus.pending}, 8'h00);

        // Latch 1 and address/strobe decode
        bus_write(3'b100, 8'h5A, 1);
        check("l1_value", bus.snd_latch1, 8'h5A);
        check("l1_fifo_pending", {7'd0, bus.pending}, 8'h00);
        check("l1_fifo_latch0", bus.snd_latch0, 8'h28);
        bus_write(3'b010, 8'h77, 1);
        check("dec_l1", bus.snd_latch1, 8'h5A);
        check("dec_latch0", bus.snd_latch0, 8'h28);
        check("dec_pending", {7'd0, bus.pending}, 8'h00);
        bus_drive(3'b000, 8'h66, 2'b01);
        step(1);
        bus_idle();
        step(1);
        check("uds_only_pending", {7'd0, bus.pending}, 8'h00);

        // Reset with three entries queued
        bus_write(3'b000, 8'h31, 1);
        bus_write(3'b000, 8'h32, 1);
        bus_write(3'b000, 8'h33, 1);
        check("mid_pending", {7'd0, bus.pending}, 8'h01);
        rst_n = 1'b0;
        #1;
        check("mid_rst_latch0", bus.snd_latch0, 8'hFF);
        check("mid_rst_latch1", bus.snd_latch1, 8'h00);
        check("mid_rst_pending", {7'd0, bus.pending}, 8'h00);
        step(1);
        rst_n = 1'b1;
        step(2);
        bus_write(3'b000, 8'h44, 1);
        check("post_rst_latch0", bus.snd_latch0, 8'h44);
        snd_read(1);
        check("post_rst_drained", {7'd0, bus.pending}, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
